// File: rtl/seq_arith_unit.sv
// Handshaked M-bit arithmetic unit: SUB (A-2B), COMP, SUM with bit clear, U2->ZM conversion.
// Define ALU_MUL_EN to add the iterative shift-add multiply on opcode 100.
module seq_arith_unit #(
    parameter int M = 8,
    parameter int N = 3
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_valid,
    input  logic [N-1:0] i_op,
    input  logic [M-1:0] i_arg_A,
    input  logic [M-1:0] i_arg_B,
    output logic         o_ready,
    output logic         o_busy,
    output logic         o_valid,
    output logic [M-1:0] o_result,
    output logic [3:0]   o_status
);

    localparam int IDX_W = $clog2(M);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   op_q;
    logic [M-1:0]   a_q, b_q;
    logic [M-1:0]   result_q, result_d;
    logic [3:0]     status_q, status_d;
    logic           accept, exec_last, op_ok, is_mul;
    logic [2:0]     op_lo;

    logic [M+1:0]   sub_s, sub_u;
    logic           sub_ovf;
    logic [M:0]     sum_u;
    logic [M-1:0]   sum_bit, conv_neg;

    assign o_ready  = (state_q != EXEC);
    assign o_busy   = (state_q == EXEC);
    assign o_valid  = (state_q == DONE);
    assign o_result = result_q;
    assign o_status = status_q;

    assign accept = i_valid && o_ready;
    assign op_ok  = ((op_q >> 3) == '0);
    assign op_lo  = op_q[2:0];

    // Signed and unsigned views of A-2B share the same low bits; only the flags differ.
    assign sub_s   = {{2{a_q[M-1]}}, a_q} - {b_q[M-1], b_q, 1'b0};
    assign sub_u   = {2'b00, a_q} - {1'b0, b_q, 1'b0};
    assign sub_ovf = !((&sub_s[M+1:M-1]) || (~|sub_s[M+1:M-1]));

    // Index beyond M-1 shifts the one-hot out entirely, so nothing is cleared.
    assign sum_u    = {1'b0, a_q} + {1'b0, b_q};
    assign sum_bit  = {{(M-1){1'b0}}, 1'b1} << b_q[IDX_W-1:0];
    assign conv_neg = ~a_q + {{(M-1){1'b0}}, 1'b1};

`ifdef ALU_MUL_EN
    localparam int CNT_W = $clog2(M);

    logic [2*M-1:0] acc_q, acc_d, mcand_q;
    logic [M-1:0]   mplr_q;
    logic [CNT_W-1:0] cnt_q;

    assign is_mul    = op_ok && (op_lo == 3'b100);
    assign exec_last = !is_mul || (cnt_q == '0);
    assign acc_d     = acc_q + (mplr_q[0] ? mcand_q : '0);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            acc_q   <= '0;
            mcand_q <= '0;
            mplr_q  <= '0;
            cnt_q   <= '0;
        end else if (accept) begin
            acc_q   <= '0;
            mcand_q <= {{M{1'b0}}, i_arg_A};
            mplr_q  <= i_arg_B;
            cnt_q   <= CNT_W'(M - 1);
        end else if (state_q == EXEC) begin
            acc_q   <= acc_d;
            mcand_q <= mcand_q << 1;
            mplr_q  <= mplr_q >> 1;
            if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        end
    end
`else
    assign is_mul    = 1'b0;
    assign exec_last = 1'b1;
`endif

    always_comb begin
        result_d = '0;
        status_d = 4'b0000;
        if (!op_ok) begin
            status_d = 4'b0001;
        end else begin
            case (op_lo)
                3'b000: begin
                    result_d    = sub_s[M-1:0];
                    status_d[3] = sub_u[M+1];
                    status_d[2] = sub_ovf;
                end
                3'b001: begin
                    result_d = (a_q < b_q) ? {{(M-1){1'b0}}, 1'b1} : '0;
                end
                3'b010: begin
                    result_d    = sum_u[M-1:0] & ~sum_bit;
                    status_d[3] = sum_u[M];
                    status_d[2] = (a_q[M-1] == b_q[M-1]) && (sum_u[M-1] != a_q[M-1]);
                end
                3'b011: begin
                    if (!a_q[M-1]) begin
                        result_d = a_q;
                    end else if (a_q[M-2:0] == '0) begin
                        status_d[0] = 1'b1;
                    end else begin
                        result_d = {1'b1, conv_neg[M-2:0]};
                    end
                end
`ifdef ALU_MUL_EN
                3'b100: begin
                    result_d    = acc_d[M-1:0];
                    status_d[2] = |acc_d[2*M-1:M];
                end
`endif
                default: status_d = 4'b0001;
            endcase
        end
        if (!status_d[0]) status_d[1] = (result_d == '0);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    if (exec_last) state_d = DONE;
            DONE:    state_d = accept ? EXEC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            status_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q <= i_op;
                a_q  <= i_arg_A;
                b_q  <= i_arg_B;
            end
            if ((state_q == EXEC) && exec_last) begin
                result_q <= result_d;
                status_q <= status_d;
            end
        end
    end

endmodule
